// File: rtl/rc4_drop_core.sv
// RC4 stream cipher with serial key load, key schedule and RC4-drop[N].
// Restart replays the same keystream from the stored key.
module rc4_drop_core #(
    parameter int KEY_MAX = 32,
    parameter int DROP    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [7:0]  key_in,
    input  logic        restart,
    input  logic        din_valid,
    input  logic [7:0]  din,
    output logic        din_ready,
    output logic        dout_valid,
    output logic [7:0]  dout,
    input  logic        dout_ready,
    output logic        ks_ready,
    output logic [15:0] byte_cnt
);

    localparam int KW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
    localparam int LW = $clog2(KEY_MAX + 1);
    localparam logic [LW-1:0] KLEN_MAX = LW'(KEY_MAX);
    localparam logic [15:0] DROP_LAST =
        (DROP > 0) ? 16'(DROP - 1) : 16'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT,
        ST_KSA,
        ST_DRP,
        ST_STREAM
    } state_t;

    state_t state;
    state_t nstate;

    logic [7:0]    s    [256];
    logic [7:0]    kbuf [KEY_MAX];
    logic [LW-1:0] klen;
    logic [KW-1:0] kptr;
    logic [LW-1:0] kptr_nx;
    logic [7:0]    i;
    logic [7:0]    j;
    logic [15:0]   dcnt;

    logic do_init;
    logic do_ksa;
    logic do_prga;
    logic accept;
    logic key_start;
    logic leave_stream;

    logic [7:0] s_i;
    logic [7:0] j_ksa;
    logic [7:0] s_jk;
    logic [7:0] i1;
    logic [7:0] j1;
    logic [7:0] si;
    logic [7:0] sj;
    logic [7:0] t;
    logic [7:0] ks;

    // KSA datapath
    assign s_i     = s[i];
    assign j_ksa   = j + s_i + kbuf[kptr];
    assign s_jk    = s[j_ksa];
    assign kptr_nx = LW'(kptr) + LW'(1);

    // PRGA datapath; keystream byte is read from the post-swap S-box
    assign i1 = i + 8'd1;
    assign si = s[i1];
    assign j1 = j + si;
    assign sj = s[j1];
    assign t  = si + sj;

    always_comb begin
        ks = s[t];
        if (t == i1) begin
            ks = sj;
        end else if (t == j1) begin
            ks = si;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            ST_IDLE: begin
                if (key_valid) nstate = ST_LOAD;
            end
            ST_LOAD: begin
                if (!key_valid) nstate = ST_INIT;
            end
            ST_INIT: begin
                nstate = key_valid ? ST_LOAD : ST_KSA;
            end
            ST_KSA: begin
                if (key_valid) begin
                    nstate = ST_LOAD;
                end else if (i == 8'hFF) begin
                    nstate = (DROP > 0) ? ST_DRP : ST_STREAM;
                end
            end
            ST_DRP: begin
                if (key_valid) begin
                    nstate = ST_LOAD;
                end else if (dcnt == DROP_LAST) begin
                    nstate = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (key_valid) begin
                    nstate = ST_LOAD;
                end else if (restart) begin
                    nstate = ST_INIT;
                end
            end
            default: nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        ks_ready     = (state == ST_STREAM);
        din_ready    = ks_ready && (!dout_valid || dout_ready);
        accept       = din_valid && din_ready;
        key_start    = key_valid && (state != ST_LOAD);
        do_init      = (state == ST_INIT) && !key_valid;
        do_ksa       = (state == ST_KSA) && !key_valid;
        do_prga      = ((state == ST_DRP) && !key_valid) || accept;
        leave_stream = ks_ready && (nstate != ST_STREAM);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            klen       <= '0;
            kptr       <= '0;
            i          <= 8'd0;
            j          <= 8'd0;
            dcnt       <= 16'd0;
            dout       <= 8'd0;
            dout_valid <= 1'b0;
            byte_cnt   <= 16'd0;
        end else begin
            if (key_start) begin
                klen <= LW'(1);
            end else if (key_valid && (klen != KLEN_MAX)) begin
                klen <= klen + LW'(1);
            end

            if (do_init) begin
                i    <= 8'd0;
                j    <= 8'd0;
                kptr <= '0;
            end else if (do_ksa) begin
                i    <= i + 8'd1;
                j    <= (i == 8'hFF) ? 8'd0 : j_ksa;
                kptr <= (kptr_nx == klen) ? '0 : kptr_nx[KW-1:0];
            end else if (do_prga) begin
                i <= i1;
                j <= j1;
            end

            if (do_ksa) begin
                dcnt <= 16'd0;
            end else if (state == ST_DRP) begin
                dcnt <= dcnt + 16'd1;
            end

            if (do_init) begin
                byte_cnt <= 16'd0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 16'd1;
            end

            if (leave_stream) begin
                dout_valid <= 1'b0;
            end else if (accept) begin
                dout       <= din ^ ks;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

    // S-box and key buffer carry no reset; INIT and LOAD define them
    always_ff @(posedge clk) begin
        if (do_init) begin
            for (int n = 0; n < 256; n++) begin
                s[n] <= 8'(n);
            end
        end else if (do_ksa) begin
            s[i]     <= s_jk;
            s[j_ksa] <= s_i;
        end else if (do_prga) begin
            s[i1] <= sj;
            s[j1] <= si;
        end
    end

    always_ff @(posedge clk) begin
        if (key_start) begin
            kbuf[0] <= key_in;
        end else if (key_valid && (klen != KLEN_MAX)) begin
            kbuf[klen[KW-1:0]] <= key_in;
        end
    end

endmodule

// File: tb/tb_rc4_drop_core.sv
// Directed bench for rc4_drop_core: known RC4 vectors, drop,
// restart replay, backpressure, key truncation, abort and reset.
module tb_rc4_drop_core;

    logic        clk;
    logic        rst_a  [3];
    logic        kv     [3];
    logic [7:0]  kin    [3];
    logic        rs     [3];
    logic        dv     [3];
    logic [7:0]  di     [3];
    logic        drdy   [3];
    logic        ovld   [3];
    logic [7:0]  dout_o [3];
    logic        dr     [3];
    logic        ksr    [3];
    logic [15:0] bc     [3];

    int total = 0;
    int bad   = 0;

    rc4_drop_core #(.KEY_MAX(32), .DROP(0)) u0 (
        .clk(clk), .rst(rst_a[0]),
        .key_valid(kv[0]), .key_in(kin[0]),
        .restart(rs[0]),
        .din_valid(dv[0]), .din(di[0]),
        .din_ready(drdy[0]),
        .dout_valid(ovld[0]), .dout(dout_o[0]),
        .dout_ready(dr[0]),
        .ks_ready(ksr[0]), .byte_cnt(bc[0])
    );

    rc4_drop_core #(.KEY_MAX(32), .DROP(3)) u1 (
        .clk(clk), .rst(rst_a[1]),
        .key_valid(kv[1]), .key_in(kin[1]),
        .restart(rs[1]),
        .din_valid(dv[1]), .din(di[1]),
        .din_ready(drdy[1]),
        .dout_valid(ovld[1]), .dout(dout_o[1]),
        .dout_ready(dr[1]),
        .ks_ready(ksr[1]), .byte_cnt(bc[1])
    );

    rc4_drop_core #(.KEY_MAX(4), .DROP(0)) u2 (
        .clk(clk), .rst(rst_a[2]),
        .key_valid(kv[2]), .key_in(kin[2]),
        .restart(rs[2]),
        .din_valid(dv[2]), .din(di[2]),
        .din_ready(drdy[2]),
        .dout_valid(ovld[2]), .dout(dout_o[2]),
        .dout_ready(dr[2]),
        .ks_ready(ksr[2]), .byte_cnt(bc[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called at a negedge; returns at the negedge after the sampling edge
    task automatic load_key(input int sel, input logic [63:0] k,
                            input int n);
        for (int m = 0; m < n; m++) begin
            kv[sel]  = 1'b1;
            kin[sel] = k[8*(n-1-m) +: 8];
            @(negedge clk);
        end
        kv[sel] = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ks(input int sel, output int n);
        n = 0;
        while (!ksr[sel] && n < 2000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic xfer(input int sel, input logic [7:0] b,
                        output logic [7:0] r, output logic v);
        int n;
        n = 0;
        dv[sel] = 1'b1;
        di[sel] = b;
        dr[sel] = 1'b1;
        #1;
        while (!drdy[sel] && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        dv[sel] = 1'b0;
        r = dout_o[sel];
        v = ovld[sel] && (n < 1000);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rst_a[d] = 1'b0;
            kv[d] = 1'b0; kin[d] = 8'h00; rs[d] = 1'b0;
            dv[d] = 1'b0; di[d] = 8'h00; dr[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({drdy[d], ovld[d], ksr[d], dout_o[d], bc[d]} !== 27'd0) begin
                bad++;
                $display("FAIL reset dut%0d: got rdy=%b vld=%b ks=%b dout=%h cnt=%0d want all 0",
                         d, drdy[d], ovld[d], ksr[d], dout_o[d], bc[d]);
            end
        end
        for (int d = 0; d < 3; d++) rst_a[d] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_plaintext();
        logic [127:0] pt;
        logic [127:0] ct;
        logic [7:0]   r;
        logic         v;
        int           n;
        pt = 128'("Plaintext");
        ct = 128'h00_BBF316E8D940AF0AD3;
        load_key(0, 64'("Key"), 3);
        wait_ks(0, n);
        total++;
        if (n !== 257) begin
            bad++;
            $display("FAIL key_latency: got %0d want 257", n);
        end
        for (int m = 0; m < 9; m++) begin
            xfer(0, pt[8*(8-m) +: 8], r, v);
            total++;
            if (!v || r !== ct[8*(8-m) +: 8]) begin
                bad++;
                $display("FAIL plaintext byte %0d: got %h vld=%b want %h",
                         m, r, v, ct[8*(8-m) +: 8]);
            end
        end
        total++;
        if (bc[0] !== 16'd9) begin
            bad++;
            $display("FAIL plaintext byte_cnt: got %0d want 9", bc[0]);
        end
    endtask

    task automatic test_restart();
        logic [127:0] pt;
        logic [127:0] ct;
        logic [7:0]   r;
        logic         v;
        int           n;
        pt = 128'("Attack at dawn");
        ct = 128'h45A01F645FC35B383552544B9BF5;
        load_key(0, 64'("Secret"), 6);
        wait_ks(0, n);
        for (int m = 0; m < 14; m++) begin
            xfer(0, pt[8*(13-m) +: 8], r, v);
            total++;
            if (!v || r !== ct[8*(13-m) +: 8]) begin
                bad++;
                $display("FAIL encrypt byte %0d: got %h want %h",
                         m, r, ct[8*(13-m) +: 8]);
            end
        end
        rs[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rs[0] = 1'b0;
        total++;
        if (ksr[0] !== 1'b0 || ovld[0] !== 1'b0) begin
            bad++;
            $display("FAIL restart_drop: got ks=%b vld=%b want 0 0",
                     ksr[0], ovld[0]);
        end
        wait_ks(0, n);
        total++;
        if (n !== 257) begin
            bad++;
            $display("FAIL restart_latency: got %0d want 257", n);
        end
        total++;
        if (bc[0] !== 16'd0) begin
            bad++;
            $display("FAIL restart byte_cnt: got %0d want 0", bc[0]);
        end
        for (int m = 0; m < 14; m++) begin
            xfer(0, ct[8*(13-m) +: 8], r, v);
            total++;
            if (!v || r !== pt[8*(13-m) +: 8]) begin
                bad++;
                $display("FAIL decrypt byte %0d: got %h want %h",
                         m, r, pt[8*(13-m) +: 8]);
            end
        end
    endtask

    task automatic test_drop();
        logic [7:0] r;
        logic       v;
        int         n;
        load_key(1, 64'("Key"), 3);
        wait_ks(1, n);
        total++;
        if (n !== 260) begin
            bad++;
            $display("FAIL drop_latency: got %0d want 260", n);
        end
        xfer(1, 8'h00, r, v);
        total++;
        if (!v || r !== 8'h81) begin
            bad++;
            $display("FAIL drop byte0: got %h want 81", r);
        end
        xfer(1, 8'h00, r, v);
        total++;
        if (!v || r !== 8'hB7) begin
            bad++;
            $display("FAIL drop byte1: got %h want b7", r);
        end
    endtask

    task automatic test_backpressure();
        logic [39:0] pt;
        logic [39:0] ct;
        logic [7:0]  held;
        logic        stalled;
        logic        acc;
        int          rx;
        int          tx;
        int          cyc;
        int          n;
        pt = 40'("pedia");
        ct = 40'h1021BF0420;
        load_key(0, 64'("Wiki"), 4);
        wait_ks(0, n);
        rx = 0; tx = 0; cyc = 0;
        stalled = 1'b0; acc = 1'b0; held = 8'h00;
        while (rx < 5 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (acc) dv[0] = 1'b0;
            if (stalled) begin
                total++;
                if (dout_o[0] !== held || ovld[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_hold: got %h vld=%b want %h vld=1",
                             dout_o[0], ovld[0], held);
                end
            end
            dr[0] = 1'($urandom_range(0, 1));
            if (!dv[0] && tx < 5 && $urandom_range(0, 2) != 0) begin
                dv[0] = 1'b1;
                di[0] = pt[8*(4-tx) +: 8];
            end
            #1;
            stalled = ovld[0] && !dr[0];
            held    = dout_o[0];
            if (ovld[0] && dr[0]) begin
                total++;
                if (rx >= 5 || dout_o[0] !== ct[8*(4-rx) +: 8]) begin
                    bad++;
                    $display("FAIL bp byte %0d: got %h want %h",
                             rx, dout_o[0], ct[8*(4-(rx % 5)) +: 8]);
                end
                rx++;
            end
            acc = dv[0] && drdy[0];
            if (acc) tx++;
        end
        @(negedge clk);
        dv[0] = 1'b0;
        dr[0] = 1'b1;
        total++;
        if (rx !== 5 || bc[0] !== 16'd5) begin
            bad++;
            $display("FAIL bp count: got rx=%0d cnt=%0d want 5 5",
                     rx, bc[0]);
        end
    endtask

    task automatic test_keymax();
        int         sb [256];
        int         kk [4];
        int         ii;
        int         jj;
        int         tmp;
        int         n;
        logic [7:0] exp_ks [8];
        logic [7:0] r;
        logic       v;
        kk = '{'h4B, 'h65, 'h79, 'h00};
        for (int m = 0; m < 256; m++) sb[m] = m;
        jj = 0;
        for (int m = 0; m < 256; m++) begin
            jj = (jj + sb[m] + kk[m % 4]) & 255;
            tmp = sb[m]; sb[m] = sb[jj]; sb[jj] = tmp;
        end
        ii = 0; jj = 0;
        for (int m = 0; m < 8; m++) begin
            ii = (ii + 1) & 255;
            jj = (jj + sb[ii]) & 255;
            tmp = sb[ii]; sb[ii] = sb[jj]; sb[jj] = tmp;
            exp_ks[m] = 8'(sb[(sb[ii] + sb[jj]) & 255]);
        end
        load_key(2, 64'h4B6579001122, 6);
        wait_ks(2, n);
        total++;
        if (n !== 257) begin
            bad++;
            $display("FAIL keymax_latency: got %0d want 257", n);
        end
        for (int m = 0; m < 8; m++) begin
            xfer(2, 8'h00, r, v);
            total++;
            if (!v || r !== exp_ks[m]) begin
                bad++;
                $display("FAIL keymax byte %0d: got %h want %h",
                         m, r, exp_ks[m]);
            end
        end
    endtask

    task automatic test_abort();
        logic [23:0] pt;
        logic [23:0] ct;
        logic [7:0]  r;
        logic        v;
        int          n;
        pt = 24'("Pla");
        ct = 24'hBBF316;
        load_key(0, 64'("Key"), 3);
        wait_ks(0, n);
        total++;
        if (n !== 257) begin
            bad++;
            $display("FAIL abort_latency: got %0d want 257", n);
        end
        for (int m = 0; m < 3; m++) begin
            xfer(0, pt[8*(2-m) +: 8], r, v);
            total++;
            if (!v || r !== ct[8*(2-m) +: 8]) begin
                bad++;
                $display("FAIL abort byte %0d: got %h want %h",
                         m, r, ct[8*(2-m) +: 8]);
            end
        end
        load_key(0, 64'("Secret"), 6);
        repeat (100) @(negedge clk);
        rst_a[0] = 1'b0;
        #1;
        total++;
        if ({drdy[0], ovld[0], ksr[0], dout_o[0], bc[0]} !== 27'd0) begin
            bad++;
            $display("FAIL ksa_reset: got rdy=%b vld=%b ks=%b dout=%h cnt=%0d want all 0",
                     drdy[0], ovld[0], ksr[0], dout_o[0], bc[0]);
        end
        @(negedge clk);
        rst_a[0] = 1'b1;
        repeat (300) @(negedge clk);
        total++;
        if (ksr[0] !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got ks=%b want 0", ksr[0]);
        end
        load_key(0, 64'("Key"), 3);
        wait_ks(0, n);
        for (int m = 0; m < 3; m++) begin
            xfer(0, pt[8*(2-m) +: 8], r, v);
            total++;
            if (!v || r !== ct[8*(2-m) +: 8]) begin
                bad++;
                $display("FAIL reload byte %0d: got %h want %h",
                         m, r, ct[8*(2-m) +: 8]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_plaintext();
        test_restart();
        test_drop();
        test_backpressure();
        test_keymax();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
